// File: rtl/mem_req_arbiter_if.sv
// Bundle of the two requester ports, the PSRAM controller handshake and the idle flag.
// The arbiter uses the slave modport; whatever drives the requests and models the controller uses master.
interface mem_req_arbiter_if;
  logic        i_a_req;
  logic        i_a_write;
  logic [23:0] i_a_address;
  logic        i_a_bank;
  logic [7:0]  i_a_wdata;
  logic        o_a_ack;
  logic [7:0]  o_a_rdata;
  logic        o_a_err;

  logic        i_b_req;
  logic        i_b_write;
  logic [23:0] i_b_address;
  logic        i_b_bank;
  logic [7:0]  i_b_wdata;
  logic        o_b_ack;
  logic [7:0]  o_b_rdata;
  logic        o_b_err;

  logic        o_mem_cs;
  logic        o_mem_write;
  logic [23:0] o_mem_address;
  logic        o_mem_bank;
  logic [7:0]  o_mem_dataToWrite;
  logic        i_mem_busy;
  logic        i_mem_dataReady;
  logic [7:0]  i_mem_dataRead;

  logic        o_idle;

  modport slave (
    input  i_a_req, i_a_write, i_a_address, i_a_bank, i_a_wdata,
    output o_a_ack, o_a_rdata, o_a_err,
    input  i_b_req, i_b_write, i_b_address, i_b_bank, i_b_wdata,
    output o_b_ack, o_b_rdata, o_b_err,
    output o_mem_cs, o_mem_write, o_mem_address, o_mem_bank, o_mem_dataToWrite,
    input  i_mem_busy, i_mem_dataReady, i_mem_dataRead,
    output o_idle
  );

  modport master (
    output i_a_req, i_a_write, i_a_address, i_a_bank, i_a_wdata,
    input  o_a_ack, o_a_rdata, o_a_err,
    output i_b_req, i_b_write, i_b_address, i_b_bank, i_b_wdata,
    input  o_b_ack, o_b_rdata, o_b_err,
    input  o_mem_cs, o_mem_write, o_mem_address, o_mem_bank, o_mem_dataToWrite,
    output i_mem_busy, i_mem_dataReady, i_mem_dataRead,
    input  o_idle
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between the CPU (A) and video (B) ports in front of the PSRAM controller,
// with a watchdog that aborts transactions the controller never finishes.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              i_clkRAM,
  input  logic              reset,
  mem_req_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        last_q, last_d;  // 1 = port B was granted last and owns the current transaction
  logic [15:0] cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        write_q, write_d;
  logic [23:0] addr_q, addr_d;
  logic        bank_q, bank_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic        b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        idle_q, idle_d;

  logic        sel_b;
  logic        fin, fin_err, fin_load;
  logic [7:0]  fin_data;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cs_d      = 1'b1;
    write_d   = write_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    b_ack_d   = 1'b0;
    b_err_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    sel_b     = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_load  = 1'b0;
    fin_data  = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (!bus_io.i_mem_busy && (bus_io.i_a_req || bus_io.i_b_req)) begin
          sel_b   = bus_io.i_b_req && (!bus_io.i_a_req || !last_q);
          last_d  = sel_b;
          write_d = sel_b ? bus_io.i_b_write   : bus_io.i_a_write;
          addr_d  = sel_b ? bus_io.i_b_address : bus_io.i_a_address;
          bank_d  = sel_b ? bus_io.i_b_bank    : bus_io.i_a_bank;
          wdata_d = sel_b ? bus_io.i_b_wdata   : bus_io.i_a_wdata;
          cnt_d   = '0;
          cs_d    = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 16'd1;
        cs_d  = 1'b0;
        if (bus_io.i_mem_busy) begin
          cs_d    = 1'b1;
          state_d = StWait;
        end else if (cnt_d == TimeoutVal) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus_io.i_mem_busy && (write_q || bus_io.i_mem_dataReady)) begin
          fin      = 1'b1;
          fin_load = !write_q;
          fin_data = bus_io.i_mem_dataRead;
        end else if (cnt_d == TimeoutVal) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
    endcase

    if (fin) begin
      state_d = StAck;
      cs_d    = 1'b1;
      // An aborted transaction reports all-ones read data regardless of direction
      if (fin_err) begin
        fin_load = 1'b1;
        fin_data = 8'hFF;
      end
      if (last_q) begin
        b_ack_d = 1'b1;
        b_err_d = fin_err;
        if (fin_load) b_rdata_d = fin_data;
      end else begin
        a_ack_d = 1'b1;
        a_err_d = fin_err;
        if (fin_load) a_rdata_d = fin_data;
      end
    end

    idle_d = (state_d == StIdle);
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      cs_q      <= 1'b1;
      write_q   <= 1'b0;
      addr_q    <= '0;
      bank_q    <= 1'b0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      wdata_q   <= wdata_d;
      a_ack_q   <= a_ack_d;
      a_err_q   <= a_err_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      idle_q    <= idle_d;
    end
  end

  assign bus_io.o_mem_cs          = cs_q;
  assign bus_io.o_mem_write       = write_q;
  assign bus_io.o_mem_address     = addr_q;
  assign bus_io.o_mem_bank        = bank_q;
  assign bus_io.o_mem_dataToWrite = wdata_q;
  assign bus_io.o_a_ack           = a_ack_q;
  assign bus_io.o_a_err           = a_err_q;
  assign bus_io.o_a_rdata         = a_rdata_q;
  assign bus_io.o_b_ack           = b_ack_q;
  assign bus_io.o_b_err           = b_err_q;
  assign bus_io.o_b_rdata         = b_rdata_q;
  assign bus_io.o_idle            = idle_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small PSRAM controller model.
module tb_mem_req_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_req_arbiter_if bus ();

  mem_req_arbiter #(.TIMEOUT_CYCLES(1023)) dut (
    .i_clkRAM (clk),
    .reset    (rst),
    .bus_io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: busy rises the cycle after it sees CS fall, stays high 16 cycles,
  // then drops together with a one-cycle dataReady.
  logic       mdl_busy, mdl_rdy, prev_cs;
  logic [7:0] mdl_data;
  int         mdl_cnt;
  logic       mdl_en;
  logic       pwr_busy;
  logic [7:0] mdl_rval;

  assign bus.i_mem_busy      = mdl_busy | pwr_busy;
  assign bus.i_mem_dataReady = mdl_rdy;
  assign bus.i_mem_dataRead  = mdl_data;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_rdy  <= 1'b0;
      mdl_cnt  <= 0;
      prev_cs  <= 1'b1;
      mdl_data <= 8'h00;
    end else begin
      prev_cs <= bus.o_mem_cs;
      mdl_rdy <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy <= 1'b0;
          mdl_rdy  <= 1'b1;
          mdl_data <= mdl_rval;
        end
        mdl_cnt <= mdl_cnt - 1;
      end else if (mdl_en && prev_cs && !bus.o_mem_cs) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 16;
      end
    end
  end

  task automatic set_a(input logic req, input logic wr, input logic [23:0] addr,
                       input logic bank, input logic [7:0] wd);
    bus.i_a_req = req; bus.i_a_write = wr; bus.i_a_address = addr;
    bus.i_a_bank = bank; bus.i_a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic [23:0] addr,
                       input logic bank, input logic [7:0] wd);
    bus.i_b_req = req; bus.i_b_write = wr; bus.i_b_address = addr;
    bus.i_b_bank = bank; bus.i_b_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_mem_cs !== 1'b1) begin
      errors++; $display("FAIL reset_cs: got %b want 1", bus.o_mem_cs);
    end
    checks++;
    if ({bus.o_mem_write, bus.o_mem_address, bus.o_mem_bank, bus.o_mem_dataToWrite} !== 34'h0) begin
      errors++; $display("FAIL reset_mem_fields: got %h want 0",
        {bus.o_mem_write, bus.o_mem_address, bus.o_mem_bank, bus.o_mem_dataToWrite});
    end
    checks++;
    if ({bus.o_a_ack, bus.o_a_err, bus.o_b_ack, bus.o_b_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err: got %b want 0000",
        {bus.o_a_ack, bus.o_a_err, bus.o_b_ack, bus.o_b_err});
    end
    checks++;
    if ({bus.o_a_rdata, bus.o_b_rdata} !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h want 0000", {bus.o_a_rdata, bus.o_b_rdata});
    end
    checks++;
    if (bus.o_idle !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got %b want 1", bus.o_idle);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int cyc;
    int cs_low;
    mdl_en = 1'b1;
    set_a(1'b1, 1'b1, 24'h001234, 1'b0, 8'h5A);
    @(negedge clk);
    cyc = 1;
    cs_low = (bus.o_mem_cs === 1'b0) ? 1 : 0;
    checks++;
    if (bus.o_mem_cs !== 1'b0) begin
      errors++; $display("FAIL wr_cs_cycle1: got %b want 0", bus.o_mem_cs);
    end
    checks++;
    if ({bus.o_mem_write, bus.o_mem_address, bus.o_mem_bank, bus.o_mem_dataToWrite}
        !== {1'b1, 24'h001234, 1'b0, 8'h5A}) begin
      errors++; $display("FAIL wr_fields: got %h want %h",
        {bus.o_mem_write, bus.o_mem_address, bus.o_mem_bank, bus.o_mem_dataToWrite},
        {1'b1, 24'h001234, 1'b0, 8'h5A});
    end
    while (bus.o_a_ack !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.o_mem_cs === 1'b0) cs_low++;
    end
    checks++;
    if (cyc != 19) begin
      errors++; $display("FAIL wr_ack_cycle: got %0d want 19", cyc);
    end
    checks++;
    if (cs_low != 2) begin
      errors++; $display("FAIL wr_cs_low_cycles: got %0d want 2", cs_low);
    end
    checks++;
    if ({bus.o_a_err, bus.o_b_ack} !== 2'b00) begin
      errors++; $display("FAIL wr_err_bport: got %b want 00", {bus.o_a_err, bus.o_b_ack});
    end
    bus.i_a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_a_ack, bus.o_idle} !== 2'b01) begin
      errors++; $display("FAIL wr_ack_one_pulse: got %b want 01", {bus.o_a_ack, bus.o_idle});
    end
  endtask

  task automatic test_single_read();
    int cyc;
    int bank_bad;
    int a_bad;
    mdl_en = 1'b1;
    mdl_rval = 8'hC3;
    set_b(1'b1, 1'b0, 24'hABCDEF, 1'b1, 8'h00);
    cyc = 0;
    bank_bad = 0;
    a_bad = 0;
    while (bus.o_b_ack !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.o_mem_bank !== 1'b1) bank_bad++;
      if (bus.o_a_ack !== 1'b0) a_bad++;
    end
    checks++;
    if (cyc != 19) begin
      errors++; $display("FAIL rd_ack_cycle: got %0d want 19", cyc);
    end
    checks++;
    if (bus.o_b_rdata !== 8'hC3) begin
      errors++; $display("FAIL rd_data: got %h want c3", bus.o_b_rdata);
    end
    checks++;
    if (bus.o_mem_address !== 24'hABCDEF) begin
      errors++; $display("FAIL rd_address: got %h want abcdef", bus.o_mem_address);
    end
    checks++;
    if (bank_bad != 0 || a_bad != 0) begin
      errors++; $display("FAIL rd_bank_aport: got bank_bad=%0d a_bad=%0d want 0 0", bank_bad, a_bad);
    end
    checks++;
    if ({bus.o_b_err, bus.o_a_rdata} !== 9'h000) begin
      errors++; $display("FAIL rd_err_arddata: got %h want 000", {bus.o_b_err, bus.o_a_rdata});
    end
    bus.i_b_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_b_ack, bus.o_b_rdata} !== {1'b0, 8'hC3}) begin
      errors++; $display("FAIL rd_data_held: got %h want 0c3", {bus.o_b_ack, bus.o_b_rdata});
    end
  endtask

  task automatic test_contention();
    logic [3:0] order;
    int n;
    int cyc;
    bit idle_seen;
    int both;
    int noidle;
    int addr_bad;
    order = '0;
    n = 0;
    cyc = 0;
    idle_seen = 1'b1;
    both = 0;
    noidle = 0;
    addr_bad = 0;
    mdl_en = 1'b1;
    mdl_rval = 8'h11;
    set_a(1'b1, 1'b0, 24'h000AAA, 1'b0, 8'h00);
    set_b(1'b1, 1'b0, 24'h000BBB, 1'b1, 8'h00);
    while (n < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.o_a_ack === 1'b1 && bus.o_b_ack === 1'b1) both++;
      if (bus.o_a_ack === 1'b1 || bus.o_b_ack === 1'b1) begin
        order[n] = bus.o_b_ack;
        if (bus.o_mem_address !== (bus.o_b_ack ? 24'h000BBB : 24'h000AAA)) addr_bad++;
        if (!idle_seen) noidle++;
        idle_seen = 1'b0;
        n++;
      end else if (bus.o_idle === 1'b1) begin
        idle_seen = 1'b1;
      end
    end
    bus.i_a_req = 1'b0;
    bus.i_b_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL cont_ack_count: got %0d want 4", n);
    end
    checks++;
    if (order !== 4'b1010) begin
      errors++; $display("FAIL cont_order (bit0 first, 1=B): got %b want 1010", order);
    end
    checks++;
    if (both != 0 || addr_bad != 0) begin
      errors++; $display("FAIL cont_exclusive: got both=%0d addr_bad=%0d want 0 0", both, addr_bad);
    end
    checks++;
    if (noidle != 0) begin
      errors++; $display("FAIL cont_idle_gap: got %0d grants without idle want 0", noidle);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    int cs_low;
    mdl_en = 1'b0;
    set_a(1'b1, 1'b0, 24'h000777, 1'b0, 8'h00);
    cyc = 0;
    cs_low = 0;
    while (bus.o_a_ack !== 1'b1 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (bus.o_mem_cs === 1'b0) cs_low++;
    end
    checks++;
    if (cyc != 1024 || cs_low != 1023) begin
      errors++; $display("FAIL to_timing: got ack_cycle=%0d cs_low=%0d want 1024 1023", cyc, cs_low);
    end
    checks++;
    if ({bus.o_a_err, bus.o_a_rdata, bus.o_mem_cs} !== {1'b1, 8'hFF, 1'b1}) begin
      errors++; $display("FAIL to_err_data_cs: got %h want %h",
        {bus.o_a_err, bus.o_a_rdata, bus.o_mem_cs}, {1'b1, 8'hFF, 1'b1});
    end
    bus.i_a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_a_ack, bus.o_a_err} !== 2'b00) begin
      errors++; $display("FAIL to_err_pulse: got %b want 00", {bus.o_a_ack, bus.o_a_err});
    end
    mdl_en = 1'b1;
    set_a(1'b1, 1'b1, 24'h000778, 1'b0, 8'h3C);
    cyc = 0;
    while (bus.o_a_ack !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 19 || bus.o_a_err !== 1'b0) begin
      errors++; $display("FAIL to_recovery: got ack_cycle=%0d err=%b want 19 0", cyc, bus.o_a_err);
    end
    bus.i_a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_powerup();
    int cs_low;
    int bad;
    int cyc;
    mdl_en = 1'b1;
    pwr_busy = 1'b1;
    set_a(1'b1, 1'b1, 24'h000042, 1'b0, 8'h99);
    cs_low = 0;
    bad = 0;
    repeat (15000) begin
      @(negedge clk);
      if (bus.o_mem_cs === 1'b0) cs_low++;
      if (bus.o_a_ack !== 1'b0 || bus.o_a_err !== 1'b0) bad++;
    end
    checks++;
    if (cs_low != 0 || bad != 0) begin
      errors++; $display("FAIL pwr_holdoff: got cs_low=%0d ack_err=%0d want 0 0", cs_low, bad);
    end
    pwr_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_mem_cs !== 1'b0) begin
      errors++; $display("FAIL pwr_grant_next_cycle: got cs=%b want 0", bus.o_mem_cs);
    end
    cyc = 1;
    while (bus.o_a_ack !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 19 || bus.o_a_err !== 1'b0) begin
      errors++; $display("FAIL pwr_service: got ack_cycle=%0d err=%b want 19 0", cyc, bus.o_a_err);
    end
    bus.i_a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int bad;
    mdl_en = 1'b1;
    set_a(1'b1, 1'b0, 24'h000321, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.o_mem_cs, bus.o_idle, bus.o_mem_address} !== {1'b1, 1'b0, 24'h000321}) begin
      errors++; $display("FAIL rstmid_in_wait: got %h want %h",
        {bus.o_mem_cs, bus.o_idle, bus.o_mem_address}, {1'b1, 1'b0, 24'h000321});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_mem_cs, bus.o_a_ack, bus.o_idle} !== 3'b101) begin
      errors++; $display("FAIL rstmid_first_edge: got cs,ack,idle=%b want 101",
        {bus.o_mem_cs, bus.o_a_ack, bus.o_idle});
    end
    checks++;
    if (bus.o_mem_address !== 24'h000000) begin
      errors++; $display("FAIL rstmid_address: got %h want 000000", bus.o_mem_address);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.o_a_ack !== 1'b0 || bus.o_b_ack !== 1'b0 || bus.o_idle !== 1'b1) bad++;
    end
    bus.i_a_req = 1'b0;
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_a_ack !== 1'b0 || bus.o_b_ack !== 1'b0 || bus.o_mem_cs !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid_no_ack: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mdl_en = 1'b0;
    pwr_busy = 1'b0;
    mdl_rval = 8'h00;
    set_a(1'b0, 1'b0, 24'h0, 1'b0, 8'h00);
    set_b(1'b0, 1'b0, 24'h0, 1'b0, 8'h00);
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_powerup();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
